// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_pkg;

    // Controller modes: normal flow, instruction refill, data refill
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2
    } hazard_state_t;

    // Refill port steering
    localparam logic MEM_SEL_I = 1'b0;
    localparam logic MEM_SEL_D = 1'b1;

    // Default architectural register index width
    localparam int DEFAULT_REG_ADDR_WIDTH = 5;

    // Default statistics counter width
    localparam int DEFAULT_STAT_WIDTH = 32;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for controller statistics.
// Clears on synchronous reset and holds at all-ones once reached.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    // Count events, sticking at the maximum value
    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use and branch hazard handling,
// plus arbitration of the shared refill port between I$ and D$ misses.
// Optional feature macro: HAZARD_STATS_EN adds saturating event counters.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH
`ifdef HAZARD_STATS_EN
   ,parameter int STAT_WIDTH = DEFAULT_STAT_WIDTH
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      d_valid,
    input  logic [REG_ADDR_WIDTH-1:0] d_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] d_rs2,
    input  logic                      d_use_rs1,
    input  logic                      d_use_rs2,
    input  logic                      e_valid,
    input  logic                      e_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] e_rd,
    input  logic                      branch_taken,
    input  logic                      icache_miss,
    input  logic                      dcache_miss,
    input  logic                      mem_ack,
    output logic                      mem_req,
    output logic                      mem_sel,
    output logic                      f_stall,
    output logic                      fd_stall,
    output logic                      fd_flush,
    output logic                      de_stall,
    output logic                      de_flush,
    output logic                      em_stall
`ifdef HAZARD_STATS_EN
   ,output logic [STAT_WIDTH-1:0]     stat_loaduse
   ,output logic [STAT_WIDTH-1:0]     stat_imiss_cyc
   ,output logic [STAT_WIDTH-1:0]     stat_dmiss_cyc
   ,output logic [STAT_WIDTH-1:0]     stat_flush
`endif
);

    hazard_state_t state_reg;
    logic          mem_req_reg;
    logic          mem_sel_reg;
    logic          load_use;
    logic          redirect;

    // A load in E feeding a source read in D; x0 is hardwired and never matches
    assign load_use = e_valid && e_is_load && (e_rd != '0) && d_valid &&
                      ((d_use_rs1 && (d_rs1 == e_rd)) || (d_use_rs2 && (d_rs2 == e_rd)));

    // Branch redirects are only honoured while E is not frozen by a D$ refill
    assign redirect = branch_taken && (state_reg != DMISS);

    // Miss FSM with registered refill request; D$ misses win so the frozen
    // memory stage is released first, the held I$ miss is picked up afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= RUN;
            mem_req_reg <= 1'b0;
            mem_sel_reg <= MEM_SEL_I;
        end else begin
            case (state_reg)
                RUN: begin
                    if (dcache_miss) begin
                        state_reg   <= DMISS;
                        mem_req_reg <= 1'b1;
                        mem_sel_reg <= MEM_SEL_D;
                    end else if (icache_miss) begin
                        state_reg   <= IMISS;
                        mem_req_reg <= 1'b1;
                        mem_sel_reg <= MEM_SEL_I;
                    end
                end
                IMISS, DMISS: begin
                    if (mem_ack) begin
                        state_reg   <= RUN;
                        mem_req_reg <= 1'b0;
                        mem_sel_reg <= MEM_SEL_I;
                    end
                end
                default: begin
                    state_reg   <= RUN;
                    mem_req_reg <= 1'b0;
                    mem_sel_reg <= MEM_SEL_I;
                end
            endcase
        end
    end

    assign mem_req = mem_req_reg;
    assign mem_sel = mem_sel_reg;

    // Stall/flush decode; a flush on a register always suppresses its stall
    always_comb begin
        f_stall  = 1'b0;
        fd_stall = 1'b0;
        fd_flush = 1'b0;
        de_stall = 1'b0;
        de_flush = 1'b0;
        em_stall = 1'b0;
        if (reset) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (state_reg == DMISS) begin
            f_stall  = 1'b1;
            fd_stall = 1'b1;
            de_stall = 1'b1;
            em_stall = 1'b1;
        end else begin
            if (state_reg == IMISS) begin
                f_stall  = 1'b1;
                fd_flush = 1'b1;
            end
            if (redirect) begin
                fd_flush = 1'b1;
                de_flush = 1'b1;
            end else if (load_use) begin
                f_stall  = 1'b1;
                de_flush = 1'b1;
                fd_stall = !fd_flush;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // Event strobes: 0 load-use bubble, 1 IMISS cycle, 2 DMISS cycle, 3 branch flush
    logic [3:0]            stat_inc;
    logic [STAT_WIDTH-1:0] stat_cnt [4];

    assign stat_inc[0] = load_use && !redirect && (state_reg != DMISS);
    assign stat_inc[1] = (state_reg == IMISS);
    assign stat_inc[2] = (state_reg == DMISS);
    assign stat_inc[3] = redirect;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stat
            sat_counter #(
                .WIDTH (STAT_WIDTH)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (stat_inc[gi]),
                .count (stat_cnt[gi])
            );
        end
    endgenerate

    assign stat_loaduse   = stat_cnt[0];
    assign stat_imiss_cyc = stat_cnt[1];
    assign stat_dmiss_cyc = stat_cnt[2];
    assign stat_flush     = stat_cnt[3];
`endif

endmodule
